// File: rtl/ma_filter_top.sv
// Multi-channel power-of-two moving-average filter with combinational raw bypass.
// Define MA_WARMUP_EN to hold off filtered output until a channel's window is full.
module ma_filter_top #(
  parameter int DW         = 8,
  parameter int NCH        = 2,
  parameter int CW         = 1,
  parameter int LOG2_DEPTH = 2
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          pass,
  input  logic          clr,
  input  logic [DW-1:0] idata,
  input  logic [CW-1:0] ichan,
  input  logic          i_flag,
  output logic [DW-1:0] odata,
  output logic [CW-1:0] ochan,
  output logic          o_flag
);

  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int SW    = DW + LOG2_DEPTH;

  logic [DW-1:0]         hist_q [NCH][DEPTH];
  logic [DW-1:0]         hist_d [NCH][DEPTH];
  logic [LOG2_DEPTH-1:0] ptr_q  [NCH];
  logic [LOG2_DEPTH-1:0] ptr_d  [NCH];
  logic [SW-1:0]         sum_q  [NCH];
  logic [SW-1:0]         sum_d  [NCH];
`ifdef MA_WARMUP_EN
  logic [LOG2_DEPTH:0]   cnt_q  [NCH];
  logic [LOG2_DEPTH:0]   cnt_d  [NCH];
`endif

  logic [DW-1:0] fdata_q, fdata_d;
  logic [CW-1:0] fchan_q, fchan_d;
  logic          fflag_q, fflag_d;

  logic [SW-1:0] sum_new;
  logic          accept;

  always_comb begin
    accept = i_flag && ({1'b0, ichan} < (CW+1)'(NCH));
  end

  always_comb begin
    hist_d  = hist_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
`ifdef MA_WARMUP_EN
    cnt_d   = cnt_q;
`endif
    fdata_d = fdata_q;
    fchan_d = fchan_q;
    fflag_d = 1'b0;
    sum_new = '0;

    if (clr) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        hist_d[c] = '{default: '0};
        ptr_d[c]  = '0;
        sum_d[c]  = '0;
`ifdef MA_WARMUP_EN
        cnt_d[c]  = '0;
`endif
      end
      fdata_d = '0;
      fchan_d = '0;
    end else if (accept) begin
      // Channel picked by compare rather than by indexing, so an unused ichan code never addresses the arrays.
      for (int unsigned c = 0; c < NCH; c++) begin
        if (ichan == CW'(c)) begin
          sum_new                = sum_q[c] + SW'(idata) - SW'(hist_q[c][ptr_q[c]]);
          hist_d[c][ptr_q[c]]    = idata;
          ptr_d[c]               = ptr_q[c] + LOG2_DEPTH'(1);
          sum_d[c]               = sum_new;
          fdata_d                = DW'(sum_new >> LOG2_DEPTH);
          fchan_d                = ichan;
`ifdef MA_WARMUP_EN
          if (cnt_q[c] != (LOG2_DEPTH+1)'(DEPTH)) begin
            cnt_d[c] = cnt_q[c] + (LOG2_DEPTH+1)'(1);
          end
          fflag_d = (cnt_d[c] == (LOG2_DEPTH+1)'(DEPTH));
`else
          fflag_d = 1'b1;
`endif
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      hist_q  <= '{default: '{default: '0}};
      ptr_q   <= '{default: '0};
      sum_q   <= '{default: '0};
`ifdef MA_WARMUP_EN
      cnt_q   <= '{default: '0};
`endif
      fdata_q <= '0;
      fchan_q <= '0;
      fflag_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
`ifdef MA_WARMUP_EN
      cnt_q   <= cnt_d;
`endif
      fdata_q <= fdata_d;
      fchan_q <= fchan_d;
      fflag_q <= fflag_d;
    end
  end

  always_comb begin
    if (pass) begin
      odata  = fdata_q;
      ochan  = fchan_q;
      o_flag = fflag_q;
    end else begin
      odata  = idata;
      ochan  = ichan;
      o_flag = i_flag;
    end
  end

endmodule

// File: doc/ma_filter_top.md
# ma_filter_top

Parametrised multi-channel moving-average filter with bypass, the next generation of the single-channel 8-bit smoothing stage that sits between the sample front end and the HR/SpO2 processing. It accepts one interleaved sample stream tagged with a channel ID (e.g. red/IR), keeps an independent power-of-two window per channel, and emits the window mean. A `pass` control selects between the filtered result and raw pass-through.

## Interface
- `DW`, 8: sample width (idata/odata).
- `NCH`, 2: number of channels, ≥1.
- `CW`, 1: channel-ID width; must satisfy 2^CW ≥ NCH.
- `LOG2_DEPTH`, 2: window depth DEPTH = 2^LOG2_DEPTH per channel, 1..5.
- `Clk`  in  1  single clock; all state updates on rising edge.
- `Rst_n`  in  1  synchronous, active-low reset, sampled on rising `Clk`.
- `pass`  in  1  1 = filtered output, 0 = raw bypass.
- `clr`  in  1  synchronous clear of all channel history (one-cycle pulse or level).
- `idata`  in  DW  input sample.
- `ichan`  in  CW  channel ID of `idata`.
- `i_flag`  in  1  sample-valid strobe, one cycle per sample.
- `odata`  out  DW  filtered mean or bypassed sample.
- `ochan`  out  CW  channel ID of `odata`.
- `o_flag`  out  1  output-valid strobe.

## Operation
- Per channel c: circular buffer of DEPTH × DW samples, write pointer `ptr[c]` (LOG2_DEPTH bits, wraps DEPTH-1 → 0), running sum `sum[c]` of width DW+LOG2_DEPTH (cannot overflow).
- Accepted sample (i_flag=1, ichan<NCH, clr=0, Rst_n=1): oldest = buf[c][ptr[c]]; sum_new = sum[c] + idata − oldest; buf[c][ptr[c]] ← idata; ptr[c] ← ptr[c]+1; sum[c] ← sum_new; filtered result = sum_new >> LOG2_DEPTH (truncation, no rounding).
- History starts zero-filled: the first DEPTH−1 outputs of a channel include zeros (ramp-up).
- ichan ≥ NCH: sample ignored, no state change, no filtered o_flag.
- clr=1: all buffers, sums, pointers, warm-up counters ← 0; any i_flag in that cycle is dropped (clr wins). Registered filtered outputs also cleared.
- Filter state updates on every accepted sample regardless of `pass`, so history stays warm across mode switches.
- pass=1: odata/ochan/o_flag driven from registered filtered path. pass=0: odata=idata, ochan=ichan, o_flag=i_flag, combinational.
- No backpressure; consumer must accept every o_flag pulse.

## Timing
- Reset (Rst_n=0 at a rising edge): all buffers, sums, pointers, counters, registered odata/ochan/o_flag ← 0. Sample presented in a reset cycle is dropped.
- Filtered latency: 1 cycle — sample on edge N, o_flag=1 with result during cycle N+1, for exactly one cycle.
- Back-to-back i_flag every cycle supported, any channel order, including the same channel repeatedly; cycle N+1 sample sees state updated by cycle N (no hazard).
- Bypass latency: 0 cycles (combinational).
- `pass` change takes effect immediately on outputs; a filtered pulse due in the cycle after a 1→0 switch is lost and the raw stream is shown instead; on 0→1 only samples after the switch appear filtered (pulse from a sample taken while pass=0 still emerges if pass=1 next cycle).

## Configuration
- `MA_WARMUP_EN` defined: per-channel counter saturating at DEPTH; filtered o_flag for channel c suppressed until its DEPTH-th accepted sample (first emitted value is a full-window mean); counters cleared by reset and clr. Bypass unaffected.
- Not defined: no counter; filtered output from first sample with zero-filled ramp-up.

## Test plan
- Reset, DEPTH=4, pass=1, ch0 samples 8,8,8,8 back-to-back → odata 2,4,6,8 with o_flag one cycle after each, ochan=0; odata=0, o_flag=0 during reset.
- Alternating ch0=100, ch1=20, four each, every cycle → ch0 outputs 25,50,75,100; ch1 outputs 5,10,15,20; ochan tracks input with 1-cycle delay.
- ch0 window full of 255, then four 0s → 191,127,63,0; sum never exceeds 1020, pointer wraps correctly.
- pass=0, idata=0x5A ch1 → odata=0x5A, ochan=1, o_flag same cycle; then pass=1, ch1 sample 0x5A → output 45 (history retained: 0x5A+0x5A over 4).
- clr asserted with i_flag (ch0=200) → no o_flag, state zeroed; next ch0 sample 40 → 10. ichan=3 with NCH=2 → no o_flag, state unchanged.
- MA_WARMUP_EN build, ch0 samples 4,8,12,16 → no o_flag for first three, fourth gives 10; clr restarts warm-up.
